// File: rtl/pccmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : pccmd_dispatch
// Description : Command dispatcher for NUM_UNITS execution units.
//               Decodes an AXI-Stream command word into op/uid/payload,
//               issues start pulses and payloads to idle units, and keeps
//               a registered busy scoreboard. Completion, error and fence
//               events collect in a sticky pending register and are
//               reported as single beats on a feedback AXI-Stream.
// Ports       : clk, rst_n (synchronous, active low)
//               s_axis_pccmd_*  command stream in
//               m_axis_pcfbk_*  feedback stream out {fence, error, done[]}
//               unit_start/unit_cmd/unit_busy  per-unit dispatch outputs
//               unit_done  per-unit completion pulses in
//               cfg_word   payload of the last CFG command
// Revision    : 1.0 - initial release
// ============================================================================
module pccmd_dispatch #(
    parameter int AXIS_PCCMD_DATA_WIDTH = 32,
    parameter int AXIS_PCFBK_DATA_WIDTH = 8,
    parameter int NUM_UNITS             = 4,
    localparam int UID_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PAYLOAD_W = AXIS_PCCMD_DATA_WIDTH - 2 - UID_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_axis_pccmd_tvalid,
    output logic                             s_axis_pccmd_tready,
    input  logic [AXIS_PCCMD_DATA_WIDTH-1:0] s_axis_pccmd_tdata,
    output logic                             m_axis_pcfbk_tvalid,
    input  logic                             m_axis_pcfbk_tready,
    output logic [AXIS_PCFBK_DATA_WIDTH-1:0] m_axis_pcfbk_tdata,
    output logic [NUM_UNITS-1:0]             unit_start,
    output logic [NUM_UNITS*PAYLOAD_W-1:0]   unit_cmd,
    input  logic [NUM_UNITS-1:0]             unit_done,
    output logic [NUM_UNITS-1:0]             unit_busy,
    output logic [PAYLOAD_W-1:0]             cfg_word
);

    localparam int              PEND_W      = NUM_UNITS + 2;
    localparam int              UID_SPAN    = 1 << UID_W;
    localparam logic [UID_W:0]  c_NUM_UNITS = NUM_UNITS[UID_W:0];
    localparam logic [1:0]      c_OP_CFG    = 2'b00;
    localparam logic [1:0]      c_OP_DISP   = 2'b01;
    localparam logic [1:0]      c_OP_BAR    = 2'b10;
    localparam logic [1:0]      c_OP_FENCE  = 2'b11;

    logic [NUM_UNITS-1:0]             r_start;
    logic [NUM_UNITS*PAYLOAD_W-1:0]   r_cmd;
    logic [NUM_UNITS-1:0]             r_busy;
    logic [PAYLOAD_W-1:0]             r_cfg;
    logic [PEND_W-1:0]                r_pend;
    logic                             r_fvalid;
    logic [AXIS_PCFBK_DATA_WIDTH-1:0] r_fdata;

    logic [1:0]                       w_op;
    logic [UID_W-1:0]                 w_uid;
    logic [PAYLOAD_W-1:0]             w_payload;
    logic                             w_uid_ok;
    logic [UID_SPAN-1:0]              w_busy_ext;
    logic                             w_all_idle;
    logic                             w_ready;
    logic                             w_acc;
    logic                             w_is_disp;
    logic [NUM_UNITS-1:0]             w_start_vec;
    logic                             w_err;
    logic                             w_fence;
    logic [PEND_W-1:0]                w_pend_all;
    logic                             w_load;
    logic [AXIS_PCFBK_DATA_WIDTH-1:0] w_fbk_next;

    always_comb begin
        w_op       = s_axis_pccmd_tdata[1:0];
        w_uid      = s_axis_pccmd_tdata[2 +: UID_W];
        w_payload  = s_axis_pccmd_tdata[AXIS_PCCMD_DATA_WIDTH-1:2+UID_W];
        w_uid_ok   = ({1'b0, w_uid} < c_NUM_UNITS);

        // Busy vector padded to the full uid range so an out-of-range uid
        // reads as idle and the command is accepted (then dropped).
        w_busy_ext = '0;
        w_busy_ext[NUM_UNITS-1:0] = r_busy;
        w_all_idle = ~|r_busy;

        w_ready = 1'b0;
        case (w_op)
            c_OP_CFG:   w_ready = 1'b1;
            c_OP_DISP:  w_ready = ~w_busy_ext[w_uid];
            c_OP_BAR:   w_ready = w_all_idle;
            c_OP_FENCE: w_ready = w_all_idle;
            default:    w_ready = 1'b0;
        endcase
        w_ready = w_ready & rst_n;

        w_acc     = s_axis_pccmd_tvalid & w_ready;
        w_is_disp = w_acc & ((w_op == c_OP_DISP) | (w_op == c_OP_BAR));

        w_start_vec = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_start_vec[u] = w_is_disp & w_uid_ok & (w_uid == UID_W'(u));
        end

        // Error sources: dispatch to a nonexistent unit, or a done pulse
        // from a unit the scoreboard considers idle.
        w_err   = (w_is_disp & ~w_uid_ok) | (|(unit_done & ~r_busy));
        w_fence = w_acc & (w_op == c_OP_FENCE);

        w_pend_all = r_pend | {w_fence, w_err, unit_done};
        w_load     = (|w_pend_all) & (~r_fvalid | m_axis_pcfbk_tready);

        w_fbk_next = '0;
        w_fbk_next[PEND_W-1:0] = w_pend_all;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start  <= '0;
            r_cmd    <= '0;
            r_busy   <= '0;
            r_cfg    <= '0;
            r_pend   <= '0;
            r_fvalid <= 1'b0;
            r_fdata  <= '0;
        end else begin
            r_start <= w_start_vec;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_start_vec[u]) begin
                    r_cmd[u*PAYLOAD_W +: PAYLOAD_W] <= w_payload;
                end
            end
            // Set wins over clear: an issue can only target an idle unit.
            r_busy <= (r_busy & ~unit_done) | w_start_vec;

            if (w_acc && (w_op == c_OP_CFG)) begin
                r_cfg <= w_payload;
            end

            // Loading moves every pending bit into the beat at once; when
            // the slot cannot load, new events merge into the sticky set.
            if (w_load) begin
                r_fvalid <= 1'b1;
                r_fdata  <= w_fbk_next;
                r_pend   <= '0;
            end else begin
                r_pend <= w_pend_all;
                if (m_axis_pcfbk_tready) begin
                    r_fvalid <= 1'b0;
                end
            end
        end
    end

    assign s_axis_pccmd_tready = w_ready;
    assign m_axis_pcfbk_tvalid = r_fvalid;
    assign m_axis_pcfbk_tdata  = r_fdata;
    assign unit_start          = r_start;
    assign unit_cmd            = r_cmd;
    assign unit_busy           = r_busy;
    assign cfg_word            = r_cfg;

endmodule
`default_nettype wire
